// File: rtl/vga_pixel_fifo.sv
// Circular RGB888 pixel FIFO feeding the VGA output controller, with burst refill requests,
// one-cycle registered pop latency, frame-start flush and underflow tracking.
module vga_pixel_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BURST     = 8,
    parameter int LOW_WATER = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFrame_Start,
    input  logic [23:0]   iWr_Data,
    input  logic          iWr_Valid,
    output logic          oWr_Ready,
    output logic          oFetch_Req,
    input  logic          iRead_Request,
    output logic [7:0]    oRed,
    output logic [7:0]    oGreen,
    output logic [7:0]    oBlue,
    output logic [AW:0]   oLevel,
    output logic          oUnderflow,
    output logic [15:0]   oUnderflow_Cnt,
    output logic [1:0]    fsm_state
);

    // Handshake: a word transfers on any cycle where iWr_Valid && oWr_Ready and no
    // iFrame_Start; oWr_Ready depends on registered state only, never on iWr_Valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_L = (AW+1)'(BURST);
    localparam logic [AW:0] LOW_L   = (AW+1)'(LOW_WATER);
    localparam logic [AW:0] LAST_L  = (AW+1)'(BURST - 1);

    fetch_state_t  state, state_next;
    logic [AW:0]   burst_cnt, cnt_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [23:0]   rgb;
    logic [23:0]   mem [DEPTH];

    logic wr_fire, store, pop_req, pop, underflow;

    assign oWr_Ready  = (state == DROP) || (level != DEPTH_L);
    assign oFetch_Req = (state == REQ);
    assign oLevel     = level;
    assign oRed       = rgb[23:16];
    assign oGreen     = rgb[15:8];
    assign oBlue      = rgb[7:0];
    assign fsm_state  = state;

    // Traffic in a frame-start cycle is ignored; words accepted while dropping are discarded.
    always_comb begin
        wr_fire   = iWr_Valid && oWr_Ready && !iFrame_Start;
        store     = wr_fire && (state != DROP);
        pop_req   = iRead_Request && !iFrame_Start;
        pop       = pop_req && (level != '0);
        underflow = pop_req && (level == '0);
    end

    always_comb begin
        state_next = state;
        cnt_next   = burst_cnt;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!iFrame_Start && (level < LOW_L) && ((DEPTH_L - level) >= BURST_L))
                    state_next = REQ;
            end
            REQ: begin
                cnt_next   = '0;
                state_next = iFrame_Start ? DROP : WAIT;
            end
            WAIT, DROP: begin
                if (wr_fire)
                    cnt_next = burst_cnt + (AW+1)'(1);
                if (wr_fire && (burst_cnt == LAST_L))
                    state_next = IDLE;
                else if (iFrame_Start)
                    state_next = DROP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state          <= IDLE;
            burst_cnt      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            rgb            <= '0;
            oUnderflow     <= 1'b0;
            oUnderflow_Cnt <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= cnt_next;
            if (iFrame_Start) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                level          <= '0;
                rgb            <= '0;
                oUnderflow_Cnt <= '0;
            end else begin
                if (store)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                // No bypass: an empty-FIFO pop blanks even if a write lands this cycle.
                rgb <= pop ? mem[rd_ptr] : '0;
                if (store && !pop)
                    level <= level + (AW+1)'(1);
                else if (pop && !store)
                    level <= level - (AW+1)'(1);
                if (underflow) begin
                    oUnderflow <= 1'b1;
                    if (oUnderflow_Cnt != 16'hFFFF)
                        oUnderflow_Cnt <= oUnderflow_Cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (store)
            mem[wr_ptr] <= iWr_Data;
    end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed scenarios plus a randomized run, all checked against
// a queue-based reference of the pixel buffer and an "words still owed" view of refill bursts.
module tb_vga_pixel_fifo;

    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int BURST     = 8;
    localparam int LOW_WATER = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iFrame_Start = 1'b0;
    logic [23:0] iWr_Data = '0;
    logic        iWr_Valid = 1'b0;
    logic        iRead_Request = 1'b0;
    logic        oWr_Ready, oFetch_Req, oUnderflow;
    logic [7:0]  oRed, oGreen, oBlue;
    logic [AW:0] oLevel;
    logic [15:0] oUnderflow_Cnt;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    vga_pixel_fifo #(.DEPTH(DEPTH), .AW(AW), .BURST(BURST), .LOW_WATER(LOW_WATER)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFrame_Start(iFrame_Start),
        .iWr_Data(iWr_Data), .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
        .oFetch_Req(oFetch_Req), .iRead_Request(iRead_Request),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oLevel(oLevel),
        .oUnderflow(oUnderflow), .oUnderflow_Cnt(oUnderflow_Cnt), .fsm_state(fsm_state)
    );

    always #5 iCLK = ~iCLK;

    // Reference model: stored pixels, last output pixel, underflow status, and the refill
    // handshake as "pulse this cycle" plus "burst words still owed" plus "dropping".
    logic [23:0] exp_q[$];
    logic [23:0] m_rgb;
    logic        m_uf;
    logic [15:0] m_ufcnt;
    logic        m_fetch;
    int          m_owed;
    logic        m_drop;
    int          m_lvl;
    bit          m_idle, m_ready, m_accept, m_store, m_fetch_next;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            exp_q.delete();
            m_rgb = '0; m_uf = 1'b0; m_ufcnt = '0;
            m_fetch = 1'b0; m_owed = 0; m_drop = 1'b0;
        end else begin
            m_lvl        = exp_q.size();
            m_idle       = !m_fetch && (m_owed == 0);
            m_ready      = m_drop || (m_lvl != DEPTH);
            m_accept     = iWr_Valid && m_ready && !iFrame_Start;
            m_store      = m_accept && !m_drop;
            m_fetch_next = m_idle && !iFrame_Start && (m_lvl < LOW_WATER) && (DEPTH - m_lvl >= BURST);
            if (m_fetch) begin
                m_owed = BURST;
                if (iFrame_Start) m_drop = 1'b1;
            end else if (m_owed > 0) begin
                if (iFrame_Start) m_drop = 1'b1;
                if (m_accept) m_owed--;
                if (m_owed == 0) m_drop = 1'b0;
            end
            if (iFrame_Start) begin
                exp_q.delete();
                m_rgb = '0;
                m_ufcnt = '0;
            end else begin
                if (iRead_Request && m_lvl > 0) begin
                    m_rgb = exp_q.pop_front();
                end else begin
                    m_rgb = '0;
                    if (iRead_Request) begin
                        m_uf = 1'b1;
                        if (m_ufcnt != 16'hFFFF) m_ufcnt++;
                    end
                end
                if (m_store) exp_q.push_back(iWr_Data);
            end
            m_fetch = m_fetch_next;
        end
    end

    // One clock of stimulus; outputs are stable and sampled 1 time unit after the edge.
    task automatic drive(input logic fs, input logic wv, input logic [23:0] wd, input logic rr);
        iFrame_Start = fs; iWr_Valid = wv; iWr_Data = wd; iRead_Request = rr;
        @(posedge iCLK);
        #1;
        iFrame_Start = 1'b0; iWr_Valid = 1'b0; iRead_Request = 1'b0;
    endtask

    task automatic reset_pulse();
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        checks++;
        if ({oLevel, oRed, oGreen, oBlue} !== '0) begin
            errors++; $display("FAIL reset_data: got level=%0d rgb=%06h want 0/000000", oLevel, {oRed, oGreen, oBlue});
        end
        checks++;
        if ({oWr_Ready, oFetch_Req, oUnderflow, oUnderflow_Cnt, fsm_state} !== {1'b1, 1'b0, 1'b0, 16'd0, ST_IDLE}) begin
            errors++; $display("FAIL reset_ctrl: got rdy=%b fetch=%b uf=%b cnt=%0d st=%0d want 1/0/0/0/0",
                               oWr_Ready, oFetch_Req, oUnderflow, oUnderflow_Cnt, fsm_state);
        end
        iRST = 1'b0;
        checks++;
        if (oFetch_Req !== 1'b0) begin
            errors++; $display("FAIL t1_cycle1_fetch: got %b want 0", oFetch_Req);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (oFetch_Req !== 1'b1 || m_fetch !== 1'b1) begin
            errors++; $display("FAIL t1_cycle2_fetch: got %b want 1", oFetch_Req);
        end
        drive(0, 0, 0, 0);
        checks++;
        if ({oFetch_Req, oLevel, oWr_Ready} !== {1'b0, 5'd0, 1'b1}) begin
            errors++; $display("FAIL t1_after_pulse: got fetch=%b level=%0d rdy=%b want 0/0/1", oFetch_Req, oLevel, oWr_Ready);
        end
    endtask

    task automatic test_write_pop();
        int pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 24'(i), 0);
            checks++;
            if (oLevel !== (AW+1)'(i)) begin
                errors++; $display("FAIL t2_write_level: got %0d want %0d", oLevel, i);
            end
        end
        for (int i = 1; i <= 11; i++) begin
            drive(0, 0, 0, (i <= 8));
            pulses += oFetch_Req;
            checks++;
            if (oFetch_Req !== m_fetch) begin
                errors++; $display("FAIL t2_fetch: got %b want %b", oFetch_Req, m_fetch);
            end
            if (i <= 8) begin
                checks++;
                if ({oRed, oGreen, oBlue} !== 24'(i) || oLevel !== (AW+1)'(8 - i)) begin
                    errors++; $display("FAIL t2_pop: got rgb=%06h level=%0d want %06h/%0d", {oRed, oGreen, oBlue}, oLevel, i, 8 - i);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL t2_pulse_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 24'h100 + 24'(i), 0);
            checks++;
            if (oLevel !== (AW+1)'(i + 1)) begin
                errors++; $display("FAIL t3_fill_level: got %0d want %0d", oLevel, i + 1);
            end
        end
        checks++;
        if (oWr_Ready !== 1'b0) begin
            errors++; $display("FAIL t3_full_ready: got %b want 0", oWr_Ready);
        end
        drive(0, 1, 24'h1FF, 1);
        checks++;
        if (oLevel !== 5'd15 || {oRed, oGreen, oBlue} !== 24'h100) begin
            errors++; $display("FAIL t3_pop_while_full: got level=%0d rgb=%06h want 15/000100", oLevel, {oRed, oGreen, oBlue});
        end
        drive(0, 1, 24'h1FF, 0);
        checks++;
        if (oLevel !== 5'd16) begin
            errors++; $display("FAIL t3_refill: got level=%0d want 16", oLevel);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1);
            checks++;
            if ({oRed, oGreen, oBlue} !== ((i < 15) ? 24'h101 + 24'(i) : 24'h1FF)) begin
                errors++; $display("FAIL t3_order: got %06h at pop %0d", {oRed, oGreen, oBlue}, i);
            end
        end
    endtask

    task automatic test_underflow();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 1);
            checks++;
            if ({oRed, oGreen, oBlue} !== 24'h0 || oUnderflow !== 1'b1 || oUnderflow_Cnt !== 16'(i)) begin
                errors++; $display("FAIL t4_underflow: got rgb=%06h uf=%b cnt=%0d want 0/1/%0d",
                                   {oRed, oGreen, oBlue}, oUnderflow, oUnderflow_Cnt, i);
            end
        end
        drive(1, 0, 0, 1);
        checks++;
        if (oUnderflow_Cnt !== 16'd0 || oUnderflow !== 1'b1) begin
            errors++; $display("FAIL t4_frame_clear: got cnt=%0d uf=%b want 0/1", oUnderflow_Cnt, oUnderflow);
        end
    endtask

    task automatic test_drop();
        reset_pulse();
        drive(0, 0, 0, 0);
        checks++;
        if (oFetch_Req !== 1'b1) begin
            errors++; $display("FAIL t5_fetch: got %b want 1", oFetch_Req);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 24'hA0 + 24'(i), 0);
        checks++;
        if (oLevel !== 5'd3) begin
            errors++; $display("FAIL t5_level3: got %0d want 3", oLevel);
        end
        drive(1, 1, 24'hBAD, 0);
        checks++;
        if (fsm_state !== ST_DROP || oLevel !== 5'd0) begin
            errors++; $display("FAIL t5_enter_drop: got st=%0d level=%0d want 3/0", fsm_state, oLevel);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 24'hC0 + 24'(i), 0);
            checks++;
            if (oLevel !== 5'd0 || oWr_Ready !== 1'b1) begin
                errors++; $display("FAIL t5_discard: got level=%0d rdy=%b want 0/1", oLevel, oWr_Ready);
            end
        end
        checks++;
        if (fsm_state !== ST_IDLE || oFetch_Req !== 1'b0) begin
            errors++; $display("FAIL t5_back_idle: got st=%0d fetch=%b want 0/0", fsm_state, oFetch_Req);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (oFetch_Req !== 1'b1) begin
            errors++; $display("FAIL t5_new_fetch: got %b want 1", oFetch_Req);
        end
    endtask

    task automatic test_async_reset();
        reset_pulse();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 24'hD0 + 24'(i), 0);
        checks++;
        if (oLevel !== 5'd5) begin
            errors++; $display("FAIL t6_pre_level: got %0d want 5", oLevel);
        end
        #2;
        iRST = 1'b1;
        #1;
        checks++;
        if ({oLevel, oRed, oGreen, oBlue, oWr_Ready, oFetch_Req, oUnderflow, oUnderflow_Cnt, fsm_state}
            !== {5'd0, 24'd0, 1'b1, 1'b0, 1'b0, 16'd0, ST_IDLE}) begin
            errors++; $display("FAIL t6_async: got level=%0d rgb=%06h rdy=%b fetch=%b st=%0d want reset values",
                               oLevel, {oRed, oGreen, oBlue}, oWr_Ready, oFetch_Req, fsm_state);
        end
        #1;
        iRST = 1'b0;
        drive(0, 0, 0, 0);
        checks++;
        if (oFetch_Req !== 1'b1) begin
            errors++; $display("FAIL t6_fetch_after: got %b want 1", oFetch_Req);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (oFetch_Req !== 1'b0) begin
            errors++; $display("FAIL t6_single_pulse: got %b want 0", oFetch_Req);
        end
    endtask

    task automatic test_random();
        reset_pulse();
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                  24'($urandom), ($urandom_range(0, 1) == 1));
            checks++;
            if (oLevel !== (AW+1)'(exp_q.size())) begin
                errors++; $display("FAIL rand_level: cycle %0d got %0d want %0d", n, oLevel, exp_q.size());
            end
            checks++;
            if ({oRed, oGreen, oBlue} !== m_rgb) begin
                errors++; $display("FAIL rand_rgb: cycle %0d got %06h want %06h", n, {oRed, oGreen, oBlue}, m_rgb);
            end
            checks++;
            if ({oWr_Ready, oFetch_Req, oUnderflow, oUnderflow_Cnt}
                !== {(m_drop || exp_q.size() != DEPTH), m_fetch, m_uf, m_ufcnt}) begin
                errors++; $display("FAIL rand_ctrl: cycle %0d got rdy=%b fetch=%b uf=%b cnt=%0d want %b/%b/%b/%0d",
                                   n, oWr_Ready, oFetch_Req, oUnderflow, oUnderflow_Cnt,
                                   (m_drop || exp_q.size() != DEPTH), m_fetch, m_uf, m_ufcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_pop();
        test_full();
        test_underflow();
        test_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
